memory_ctrl: RTL and testbench

- Next-generation parametrised word memory with a valid/ready request port.
- Read data pipeline is configurable to 1 or 2 cycles.
- A hardware clear engine zeroes every word after reset and on demand.
- Sits between the CPU datapath and storage; replaces the single-cycle combinational-read memory in pipelined builds.

---
 rtl/memory_ctrl.sv | 146 ++++++++++++++
 tb/tb_memory_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// Word memory with a valid/ready request port, 1- or 2-cycle read pipeline and a
// hardware clear engine. Define MEMORY_CTRL_PARITY_EN to add per-word even parity.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 4
`endif

module memory_ctrl #(
  parameter int WORD_SIZE    = `WORD_SIZE,
  parameter int ADDR_SIZE    = `ADDR_SIZE,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  input  logic                 clear_req,
  output logic                 busy
`ifdef MEMORY_CTRL_PARITY_EN
  ,
  input  logic                 inj_parity_err,
  output logic                 parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] MAX_ADDR = '1;
`ifdef MEMORY_CTRL_PARITY_EN
  localparam int MEM_W = WORD_SIZE + 1;
`else
  localparam int MEM_W = WORD_SIZE;
`endif

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("memory_ctrl: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                 state;
  logic [ADDR_SIZE-1:0]   clr_cnt;
  logic [MEM_W-1:0]       mem [DEPTH];
  logic                   accept;
  logic                   rd_accept;
  logic [MEM_W-1:0]       wr_word;
  logic                   src_vld;
  logic [MEM_W-1:0]       src_word;

  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;

  // Stored parity bit is even parity of the data, optionally inverted to inject an error.
  always_comb begin
`ifdef MEMORY_CTRL_PARITY_EN
    wr_word = {(^req_wdata) ^ inj_parity_err, req_wdata};
`else
    wr_word = req_wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == MAX_ADDR) begin
            state     <= READY;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // A write accepted alongside clear_req still lands; the clear starts on the next edge.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && req_write) begin
      mem[req_addr] <= wr_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             vld_p0;
    logic [MEM_W-1:0] word_p0;

    // Stage p0: array sampled at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p0 <= 1'b0;
      else        vld_p0 <= rd_accept;
    end

    always_ff @(posedge clk) begin
      if (rd_accept) word_p0 <= mem[req_addr];
    end

    assign src_vld  = vld_p0;
    assign src_word = word_p0;
  end else begin : g_lat1
    assign src_vld  = rd_accept;
    assign src_word = mem[req_addr];
  end

  // Output stage: rsp_data holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= src_vld;
      if (src_vld) rsp_data <= src_word[WORD_SIZE-1:0];
    end
  end

`ifdef MEMORY_CTRL_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= src_vld && (^src_word);
  end
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl: two instances (read latency 1 and 2) share stimulus;
// a reference model predicts ready/busy and read responses, monitors pop and compare.
module tb_memory_ctrl;
  localparam int W = 8;
  localparam int A = 4;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_write = 1'b0, clear_req = 1'b0, inj = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         ready1, busy1, rv1, pe1, ready2, busy2, rv2, pe2;
  logic [W-1:0] rd1, rd2;

  memory_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_data(rd1), .clear_req(clear_req), .busy(busy1)
`ifdef MEMORY_CTRL_PARITY_EN
    , .inj_parity_err(inj), .parity_err(pe1)
`endif
  );

  memory_ctrl #(.WORD_SIZE(W), .ADDR_SIZE(A), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_data(rd2), .clear_req(clear_req), .busy(busy2)
`ifdef MEMORY_CTRL_PARITY_EN
    , .inj_parity_err(inj), .parity_err(pe2)
`endif
  );

`ifndef MEMORY_CTRL_PARITY_EN
  assign pe1 = 1'b0;
  assign pe2 = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         p;
    int           due;
  } rsp_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] mm [D];
  logic         pb [D];
  int           cl;
  logic         exp_ready;
  rsp_t         q [2][$];
  logic [W-1:0] last [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < D; i++) begin
      mm[i] = '0;
      pb[i] = 1'b0;
    end
  endtask

  // Called at a falling edge; drives one request, advances the model by one rising edge.
  task automatic step(input logic v, input logic w, input logic [A-1:0] a,
                      input logic [W-1:0] d, input logic c, input logic inj_i);
    rsp_t r;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; clear_req = c; inj = inj_i;
    check("req_ready_L1", ready1, exp_ready);
    check("req_ready_L2", ready2, exp_ready);
    check("busy_L1", busy1, !exp_ready);
    check("busy_L2", busy2, !exp_ready);
    if (v && exp_ready) begin
      if (w) begin
        mm[a] = d;
        pb[a] = inj_i;
      end else begin
        r.d = mm[a];
        r.p = pb[a];
        r.due = cyc + 1;
        q[0].push_back(r);
        r.due = cyc + 2;
        q[1].push_back(r);
      end
    end
    if (cl > 0) begin
      cl--;
      exp_ready = (cl == 0);
    end else if (c) begin
      cl = D;
      exp_ready = 1'b0;
      model_zero();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [A-1:0] a);
    step(1'b1, 1'b0, a, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  // Called at a falling edge; asserts reset between edges and releases on a later falling edge.
  task automatic apply_reset(input int hold);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; clear_req = 1'b0; inj = 1'b0;
    #1;
    check("rst_rsp_valid_L1", rv1, 0);
    check("rst_rsp_valid_L2", rv2, 0);
    check("rst_rsp_data_L1", rd1, 0);
    check("rst_rsp_data_L2", rd2, 0);
    check("rst_busy", busy1, 1);
    check("rst_req_ready", ready1, 0);
    check("rst_parity_err", pe1 | pe2, 0);
    q[0].delete();
    q[1].delete();
    last[0] = '0;
    last[1] = '0;
    model_zero();
    cl = D;
    exp_ready = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mon(input int k, input logic v, input logic [W-1:0] data, input logic pe);
    rsp_t e;
    if (v) begin
      if (q[k].size() == 0) begin
        check($sformatf("unexpected_rsp_L%0d", k + 1), 1, 0);
      end else begin
        e = q[k].pop_front();
        check($sformatf("rsp_data_L%0d", k + 1), data, e.d);
        check($sformatf("rsp_cycle_L%0d", k + 1), cyc, e.due);
`ifdef MEMORY_CTRL_PARITY_EN
        check($sformatf("parity_err_L%0d", k + 1), pe, e.p);
`endif
      end
      last[k] = data;
    end else begin
      check($sformatf("rsp_hold_L%0d", k + 1), data, last[k]);
      check($sformatf("parity_idle_L%0d", k + 1), pe, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, rv1, rd1, pe1);
      mon(1, rv2, rd2, pe2);
    end
  end

  initial begin
    @(negedge clk);
    apply_reset(2);

    // Power-up clear, then every word reads zero
    idle(D);
    for (int i = 0; i < D; i++) rd(A'(i));

    // Write followed immediately by read of the same address
    wr(4'd3, 8'hA5);
    rd(4'd3);

    // Back-to-back reads
    wr(4'd0, 8'h11);
    wr(4'd1, 8'h22);
    wr(4'd2, 8'h33);
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);

    // Clear on demand: read accepted with clear_req returns pre-clear data; requests stall
    for (int i = 0; i < D; i++) wr(A'(i), 8'hFF);
    step(1'b1, 1'b0, 4'd9, '0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, 1'b1, A'(i), 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) rd(A'(i));

    // Reset with a read in flight drops the response
    wr(4'd6, 8'h5A);
    rd(4'd6);
    apply_reset(2);
    idle(D);

    // Reset mid-clear restarts the full clear
    for (int i = 0; i < D; i++) wr(A'(i), 8'hFF);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(7);
    apply_reset(1);
    idle(D);
    for (int i = 0; i < D; i++) rd(A'(i));

`ifdef MEMORY_CTRL_PARITY_EN
    step(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b1);
    rd(4'd5);
    wr(4'd5, 8'h3C);
    rd(4'd5);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v, w, c, ij;
      logic [A-1:0] a;
      logic [W-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) != 0;
      a = A'($urandom_range(0, D - 1));
      d = W'($urandom());
      c = ($urandom_range(0, 59) == 0);
`ifdef MEMORY_CTRL_PARITY_EN
      ij = ($urandom_range(0, 3) == 0);
`else
      ij = 1'b0;
`endif
      step(v, w, a, d, c, ij);
    end

    idle(4);
    check("drain_L1", q[0].size(), 0);
    check("drain_L2", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
